// File: rtl/frame_grid_if.sv
// Pixel bus between the raster source and the board-frame stage:
// raster position in, tile-local coordinates plus tile style/letter out.
interface frame_grid_if #(
  parameter int unsigned SW = 7
);
  logic [10:0]   x;
  logic [10:0]   y;
  logic [SW-1:0] sub_x;
  logic [SW-1:0] sub_y;
  logic [2:0]    style;
  logic [4:0]    letter;
  logic          valid;

  modport master (
    output x, y,
    input  sub_x, sub_y, style, letter, valid
  );

  modport slave (
    input  x, y,
    output sub_x, sub_y, style, letter, valid
  );
endinterface

// File: rtl/frame_grid.sv
// Board-frame pixel stage: maps raster (x, y) onto a ROWS x COLS tile grid,
// looks up each tile's style/letter byte and emits tile-local coordinates
// two cycles later. A row-reveal sequencer, paced by frame ticks, holds
// tile styles of one row at 0 until each column's turn comes.
module frame_grid #(
  parameter int unsigned COLS        = 5,
  parameter int unsigned ROWS        = 6,
  parameter int unsigned TILE        = 76,
  parameter int unsigned GAP         = 0,
  parameter int unsigned X0          = 130,
  parameter int unsigned Y0          = 12,
  parameter int unsigned FLIP_FRAMES = 8,
  localparam int unsigned RW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  frame_grid_if.slave            pix,
  input  logic                   frame_tick,
  input  logic [ROWS*COLS*8-1:0] status,
  input  logic                   reveal_start,
  input  logic [RW-1:0]          reveal_row,
  output logic                   reveal_busy,
  output logic                   reveal_done
);
  localparam int unsigned PITCH = TILE + GAP;
  localparam int unsigned GW    = COLS * PITCH - GAP;
  localparam int unsigned GH    = ROWS * PITCH - GAP;
  localparam int unsigned SW    = $clog2(TILE);

  typedef enum logic {S_IDLE, S_REVEAL} state_t;

  state_t        state_q;
  logic [RW-1:0] rrow_q;
  logic [2:0]    rcol_q;
  logic [7:0]    tcnt_q;

  // Stage 1 signals
  logic [10:0]   dx, dy, px, py;
  logic          in_x, in_y;
  logic          tile_d, tile_q;
  logic [2:0]    col_d, col_q, row_d, row_q;
  logic [SW-1:0] px_d, px_q, py_d, py_q;

  // Stage 2 signals
  logic [7:0]    byte_sel;
  logic          masked;
  logic          valid_d, valid_q;
  logic [SW-1:0] sub_x_d, sub_x_q, sub_y_d, sub_y_q;
  logic [2:0]    style_d, style_q;
  logic [4:0]    letter_d, letter_q;

  // Locate the pixel: range test at 12 bits so x < X0 never wraps into the
  // grid; division by PITCH is a compare ladder against column/row starts.
  always_comb begin
    dx    = pix.x - 11'(X0);
    dy    = pix.y - 11'(Y0);
    in_x  = ({1'b0, pix.x} >= 12'(X0)) && ({1'b0, pix.x} < 12'(X0 + GW));
    in_y  = ({1'b0, pix.y} >= 12'(Y0)) && ({1'b0, pix.y} < 12'(Y0 + GH));
    col_d = '0;
    for (int unsigned k = 1; k < COLS; k++)
      if (dx >= 11'(k * PITCH)) col_d = 3'(k);
    row_d = '0;
    for (int unsigned k = 1; k < ROWS; k++)
      if (dy >= 11'(k * PITCH)) row_d = 3'(k);
    px     = dx - 11'(col_d * PITCH);
    py     = dy - 11'(row_d * PITCH);
    tile_d = in_x && in_y && (px < 11'(TILE)) && (py < 11'(TILE));
    px_d   = tile_d ? px[SW-1:0] : '0;
    py_d   = tile_d ? py[SW-1:0] : '0;
  end

  // Stage 1 registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tile_q <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      px_q   <= '0;
      py_q   <= '0;
    end else begin
      tile_q <= tile_d;
      col_q  <= col_d;
      row_q  <= row_d;
      px_q   <= px_d;
      py_q   <= py_d;
    end
  end

  // Fetch the tile byte live from status and apply the reveal mask
  always_comb begin
    byte_sel = '0;
    for (int unsigned r = 0; r < ROWS; r++)
      for (int unsigned c = 0; c < COLS; c++)
        if (row_q == 3'(r) && col_q == 3'(c))
          byte_sel = status[(r*COLS+c)*8 +: 8];
    masked = (state_q == S_REVEAL) && (row_q == 3'(rrow_q)) && (col_q >= rcol_q);
    valid_d  = tile_q;
    sub_x_d  = '0;
    sub_y_d  = '0;
    style_d  = '0;
    letter_d = 5'h1f;
    if (tile_q) begin
      sub_x_d  = px_q;
      sub_y_d  = py_q;
      style_d  = masked ? 3'd0 : byte_sel[7:5];
      letter_d = byte_sel[4:0];
    end
  end

  // Stage 2 registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      sub_x_q  <= '0;
      sub_y_q  <= '0;
      style_q  <= '0;
      letter_q <= 5'h1f;
    end else begin
      valid_q  <= valid_d;
      sub_x_q  <= sub_x_d;
      sub_y_q  <= sub_y_d;
      style_q  <= style_d;
      letter_q <= letter_d;
    end
  end

  assign pix.valid  = valid_q;
  assign pix.sub_x  = sub_x_q;
  assign pix.sub_y  = sub_y_q;
  assign pix.style  = style_q;
  assign pix.letter = letter_q;

  // Reveal sequencer: one column unmasked every FLIP_FRAMES frame ticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rrow_q      <= '0;
      rcol_q      <= '0;
      tcnt_q      <= '0;
      reveal_busy <= 1'b0;
      reveal_done <= 1'b0;
    end else begin
      reveal_done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (reveal_start && (32'(reveal_row) < ROWS)) begin
            rrow_q      <= reveal_row;
            rcol_q      <= '0;
            tcnt_q      <= '0;
            state_q     <= S_REVEAL;
            reveal_busy <= 1'b1;
          end
        end
        S_REVEAL: begin
          if (frame_tick) begin
            if (tcnt_q == 8'(FLIP_FRAMES - 1)) begin
              tcnt_q <= '0;
              rcol_q <= rcol_q + 3'd1;
              if (rcol_q == 3'(COLS - 1)) begin
                state_q     <= S_IDLE;
                reveal_busy <= 1'b0;
                reveal_done <= 1'b1;
              end
            end else begin
              tcnt_q <= tcnt_q + 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_grid.sv
// Directed bench for frame_grid: default geometry with fast reveal (A),
// gapped geometry (B), and a small grid swept against a reference model (C).
`timescale 1ns/1ps
module tb_frame_grid;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_grid_if #(.SW(7)) ifa ();
  frame_grid_if #(.SW(7)) ifb ();
  frame_grid_if #(.SW(5)) ifc ();

  logic [239:0] stat_a, stat_b;
  logic [95:0]  stat_c;
  logic         tick_a, start_a;
  logic [2:0]   row_a;
  logic         busy_a, done_a, busy_b, done_b, busy_c, done_c;

  frame_grid #(.FLIP_FRAMES(2)) dut_a (
    .clk(clk), .rst(rst_n), .pix(ifa), .frame_tick(tick_a), .status(stat_a),
    .reveal_start(start_a), .reveal_row(row_a),
    .reveal_busy(busy_a), .reveal_done(done_a)
  );

  frame_grid #(.GAP(4)) dut_b (
    .clk(clk), .rst(rst_n), .pix(ifb), .frame_tick(1'b0), .status(stat_b),
    .reveal_start(1'b0), .reveal_row(3'd0),
    .reveal_busy(busy_b), .reveal_done(done_b)
  );

  frame_grid #(.ROWS(3), .COLS(4), .TILE(20), .GAP(3)) dut_c (
    .clk(clk), .rst(rst_n), .pix(ifc), .frame_tick(1'b0), .status(stat_c),
    .reveal_start(1'b0), .reveal_row(2'd0),
    .reveal_busy(busy_c), .reveal_done(done_c)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt_a = 0;

  always @(negedge clk) if (done_a === 1'b1) done_cnt_a++;

  typedef struct {
    int          x;
    int          y;
    logic [22:0] exp;
  } pv_t;

  function automatic logic [22:0] mk(logic v, int sx, int sy, int st, int lt);
    return {v, 7'(sx), 7'(sy), 3'(st), 5'(lt)};
  endfunction

  // Reference for grid C: ROWS=3 COLS=4 TILE=20 GAP=3 X0=130 Y0=12
  function automatic logic [18:0] model_c(int x, int y);
    int dx, dy, col, row, px, py;
    logic [7:0] b;
    if (x < 130 || x >= 130 + 89 || y < 12 || y >= 12 + 66)
      return {1'b0, 5'd0, 5'd0, 3'd0, 5'h1f};
    dx = x - 130; dy = y - 12;
    col = dx / 23; px = dx % 23;
    row = dy / 23; py = dy % 23;
    if (px >= 20 || py >= 20) return {1'b0, 5'd0, 5'd0, 3'd0, 5'h1f};
    b = stat_c[(row*4+col)*8 +: 8];
    return {1'b1, 5'(px), 5'(py), b[7:5], b[4:0]};
  endfunction

  task automatic drive_a(input int px, input int py);
    ifa.x = 11'(px); ifa.y = 11'(py);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input int px, input int py);
    ifb.x = 11'(px); ifb.y = 11'(py);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick;
    tick_a = 1'b1;
    @(posedge clk); #1;
    tick_a = 1'b0;
  endtask

  task automatic test_reset;
    ifa.x = 11'd130; ifa.y = 11'd12;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ifa.valid, ifa.sub_x, ifa.sub_y, ifa.style, ifa.letter, busy_a, done_a} !== {mk(0,0,0,0,31), 2'b00}) begin
      n_err++;
      $display("FAIL reset_a got=%h want=%h", {ifa.valid, ifa.sub_x, ifa.sub_y, ifa.style, ifa.letter, busy_a, done_a}, {mk(0,0,0,0,31), 2'b00});
    end
    n_cmp++;
    if ({ifb.valid, ifb.letter, busy_b, done_b, ifc.valid, ifc.letter, busy_c, done_c} !== {1'b0, 5'h1f, 2'b00, 1'b0, 5'h1f, 2'b00}) begin
      n_err++;
      $display("FAIL reset_bc got=%b want=%b", {ifb.valid, ifb.letter, busy_b, done_b, ifc.valid, ifc.letter, busy_c, done_c}, {1'b0, 5'h1f, 2'b00, 1'b0, 5'h1f, 2'b00});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({ifa.valid, ifa.letter} !== {1'b0, 5'h1f}) begin
      n_err++;
      $display("FAIL reset_first_blank got=%b want=%b", {ifa.valid, ifa.letter}, {1'b0, 5'h1f});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({ifa.valid, ifa.style, ifa.letter} !== {1'b1, 3'd2, 5'd3}) begin
      n_err++;
      $display("FAIL reset_first_tile got=%b want=%b", {ifa.valid, ifa.style, ifa.letter}, {1'b1, 3'd2, 5'd3});
    end
  endtask

  task automatic test_pixel_map;
    pv_t tv[11];
    logic [22:0] got;
    tv[0]  = '{130, 12, mk(1, 0, 0, 2, 3)};
    tv[1]  = '{509, 467, mk(1, 75, 75, 1, 5)};
    tv[2]  = '{129, 12, mk(0, 0, 0, 0, 31)};
    tv[3]  = '{130, 468, mk(0, 0, 0, 0, 31)};
    tv[4]  = '{205, 12, mk(1, 75, 0, 2, 3)};
    tv[5]  = '{206, 12, mk(1, 0, 0, 4, 10)};
    tv[6]  = '{0, 0, mk(0, 0, 0, 0, 31)};
    tv[7]  = '{2047, 2047, mk(0, 0, 0, 0, 31)};
    tv[8]  = '{510, 12, mk(0, 0, 0, 0, 31)};
    tv[9]  = '{130, 11, mk(0, 0, 0, 0, 31)};
    tv[10] = '{135, 100, mk(1, 5, 12, 0, 0)};
    for (int i = 0; i < 11; i++) begin
      drive_a(tv[i].x, tv[i].y);
      got = {ifa.valid, ifa.sub_x, ifa.sub_y, ifa.style, ifa.letter};
      n_cmp++;
      if (got !== tv[i].exp) begin
        n_err++;
        $display("FAIL pix_a x=%0d y=%0d got=%h want=%h", tv[i].x, tv[i].y, got, tv[i].exp);
      end
    end
  endtask

  task automatic test_status_live;
    drive_a(130, 12);
    stat_a[7:0] = 8'hE1;
    @(posedge clk); #1;
    n_cmp++;
    if ({ifa.valid, ifa.style, ifa.letter} !== {1'b1, 3'd7, 5'd1}) begin
      n_err++;
      $display("FAIL status_live got=%b want=%b", {ifa.valid, ifa.style, ifa.letter}, {1'b1, 3'd7, 5'd1});
    end
    stat_a[7:0] = 8'h43;
  endtask

  task automatic test_gap;
    pv_t tv[8];
    logic [22:0] got;
    tv[0] = '{206, 12, mk(0, 0, 0, 0, 31)};
    tv[1] = '{210, 12, mk(1, 0, 0, 6, 7)};
    tv[2] = '{209, 12, mk(0, 0, 0, 0, 31)};
    tv[3] = '{525, 12, mk(1, 75, 0, 1, 30)};
    tv[4] = '{526, 12, mk(0, 0, 0, 0, 31)};
    tv[5] = '{130, 88, mk(0, 0, 0, 0, 31)};
    tv[6] = '{130, 92, mk(1, 0, 0, 2, 18)};
    tv[7] = '{130, 91, mk(0, 0, 0, 0, 31)};
    for (int i = 0; i < 8; i++) begin
      drive_b(tv[i].x, tv[i].y);
      got = {ifb.valid, ifb.sub_x, ifb.sub_y, ifb.style, ifb.letter};
      n_cmp++;
      if (got !== tv[i].exp) begin
        n_err++;
        $display("FAIL gap_b x=%0d y=%0d got=%h want=%h", tv[i].x, tv[i].y, got, tv[i].exp);
      end
    end
  endtask

  task automatic test_reveal;
    int base;
    logic [2:0] want_st;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 5; c++)
        stat_a[(r*5+c)*8 +: 8] = {3'd3, 5'(r*5+c)};
    base = done_cnt_a;
    // tick in the start cycle must not count
    start_a = 1'b1; row_a = 3'd2; tick_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; tick_a = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL reveal_busy_rise got=%b want=1", busy_a);
    end
    for (int c = 0; c < 5; c++) begin
      drive_a(130 + c*76 + 10, 169);
      n_cmp++;
      if ({ifa.valid, ifa.style, ifa.letter} !== {1'b1, 3'd0, 5'(10+c)}) begin
        n_err++;
        $display("FAIL reveal_init c=%0d got=%b want=%b", c, {ifa.valid, ifa.style, ifa.letter}, {1'b1, 3'd0, 5'(10+c)});
      end
    end
    drive_a(130 + 3*76 + 1, 89);
    n_cmp++;
    if ({ifa.style, ifa.letter} !== {3'd3, 5'd8}) begin
      n_err++;
      $display("FAIL reveal_other_row got=%b want=%b", {ifa.style, ifa.letter}, {3'd3, 5'd8});
    end
    for (int k = 1; k <= 10; k++) begin
      if (k % 2 == 0) drive_a(130 + (k/2 - 1)*76 + 2, 166);
      pulse_tick();
      n_cmp++;
      if ({busy_a, done_a} !== {1'(k < 10), 1'(k == 10)}) begin
        n_err++;
        $display("FAIL reveal_flags tick=%0d got=%b want=%b", k, {busy_a, done_a}, {1'(k < 10), 1'(k == 10)});
      end
      if (k % 2 == 0) begin
        n_cmp++;
        if (ifa.style !== 3'd0) begin
          n_err++;
          $display("FAIL unmask_early tick=%0d got=%0d want=0", k, ifa.style);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ifa.style !== 3'd3) begin
          n_err++;
          $display("FAIL unmask_edge tick=%0d got=%0d want=3", k, ifa.style);
        end
      end
      if (k == 3) begin
        start_a = 1'b1; row_a = 3'd4;
        @(posedge clk); #1;
        start_a = 1'b0;
        drive_a(130 + 4*76 + 3, 12 + 4*76 + 3);
        n_cmp++;
        if ({busy_a, ifa.style, ifa.letter} !== {1'b1, 3'd3, 5'd24}) begin
          n_err++;
          $display("FAIL start_while_busy got=%b want=%b", {busy_a, ifa.style, ifa.letter}, {1'b1, 3'd3, 5'd24});
        end
      end
      for (int c = 0; c < 5; c++) begin
        drive_a(130 + c*76 + 10, 169);
        want_st = (k == 10 || c < k/2) ? 3'd3 : 3'd0;
        n_cmp++;
        if ({ifa.style, ifa.letter} !== {want_st, 5'(10+c)}) begin
          n_err++;
          $display("FAIL reveal_row tick=%0d c=%0d got=%b want=%b", k, c, {ifa.style, ifa.letter}, {want_st, 5'(10+c)});
        end
      end
    end
    n_cmp++;
    if (done_cnt_a - base !== 1) begin
      n_err++;
      $display("FAIL done_pulses got=%0d want=1", done_cnt_a - base);
    end
  endtask

  task automatic test_reveal_ignore;
    int base;
    base = done_cnt_a;
    start_a = 1'b1; row_a = 3'd6;
    @(posedge clk); #1;
    row_a = 3'd7;
    @(posedge clk); #1;
    start_a = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL bad_row_busy got=%b want=0", busy_a);
    end
    repeat (3) pulse_tick();
    n_cmp++;
    if ({busy_a, 32'(done_cnt_a - base)} !== {1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL bad_row_state busy=%b dones=%0d want busy=0 dones=0", busy_a, done_cnt_a - base);
    end
  endtask

  task automatic test_reset_mid_reveal;
    int base;
    base = done_cnt_a;
    start_a = 1'b1; row_a = 3'd0;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) pulse_tick();
    drive_a(130 + 76 + 1, 13);
    n_cmp++;
    if ({ifa.valid, ifa.style, ifa.letter} !== {1'b1, 3'd0, 5'd1}) begin
      n_err++;
      $display("FAIL mid_masked got=%b want=%b", {ifa.valid, ifa.style, ifa.letter}, {1'b1, 3'd0, 5'd1});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ifa.valid, ifa.sub_x, ifa.sub_y, ifa.style, ifa.letter, busy_a, done_a} !== {mk(0,0,0,0,31), 2'b00}) begin
      n_err++;
      $display("FAIL async_reset got=%h want=%h", {ifa.valid, ifa.sub_x, ifa.sub_y, ifa.style, ifa.letter, busy_a, done_a}, {mk(0,0,0,0,31), 2'b00});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({ifa.valid, ifa.letter, busy_a} !== {1'b0, 5'h1f, 1'b0}) begin
      n_err++;
      $display("FAIL post_reset_blank got=%b want=%b", {ifa.valid, ifa.letter, busy_a}, {1'b0, 5'h1f, 1'b0});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({ifa.valid, ifa.style, ifa.letter} !== {1'b1, 3'd3, 5'd1}) begin
      n_err++;
      $display("FAIL post_reset_tile got=%b want=%b", {ifa.valid, ifa.style, ifa.letter}, {1'b1, 3'd3, 5'd1});
    end
    repeat (4) pulse_tick();
    n_cmp++;
    if ({busy_a, 32'(done_cnt_a - base)} !== {1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL reset_no_done busy=%b dones=%0d want busy=0 dones=0", busy_a, done_cnt_a - base);
    end
    start_a = 1'b1; row_a = 3'd0;
    @(posedge clk); #1;
    start_a = 1'b0;
    drive_a(131, 13);
    n_cmp++;
    if ({busy_a, ifa.style} !== {1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL restart got=%b want=%b", {busy_a, ifa.style}, {1'b1, 3'd0});
    end
    repeat (2) pulse_tick();
    drive_a(131, 13);
    n_cmp++;
    if (ifa.style !== 3'd3) begin
      n_err++;
      $display("FAIL restart_col0 got=%0d want=3", ifa.style);
    end
    drive_a(207, 13);
    n_cmp++;
    if (ifa.style !== 3'd0) begin
      n_err++;
      $display("FAIL restart_col1 got=%0d want=0", ifa.style);
    end
  endtask

  task automatic test_stream;
    logic [18:0] q[$];
    logic [18:0] got, want;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        stat_c[(r*4+c)*8 +: 8] = 8'((r*4+c)*29 + 7);
    for (int y = 0; y < 100; y++) begin
      for (int x = 100; x < 250; x++) begin
        if (q.size() == 2) begin
          want = q.pop_front();
          got = {ifc.valid, ifc.sub_x, ifc.sub_y, ifc.style, ifc.letter};
          n_cmp++;
          if (got !== want) begin
            n_err++;
            $display("FAIL stream_c got=%h want=%h", got, want);
          end
        end
        ifc.x = 11'(x); ifc.y = 11'(y);
        q.push_back(model_c(x, y));
        @(posedge clk); #1;
      end
    end
    repeat (2) begin
      want = q.pop_front();
      got = {ifc.valid, ifc.sub_x, ifc.sub_y, ifc.style, ifc.letter};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL stream_c_tail got=%h want=%h", got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    ifa.x = '0; ifa.y = '0;
    ifb.x = '0; ifb.y = '0;
    ifc.x = '0; ifc.y = '0;
    tick_a = 1'b0; start_a = 1'b0; row_a = '0;
    stat_a = '0; stat_b = '0; stat_c = '0;
    stat_a[7:0]     = 8'h43;
    stat_a[15:8]    = 8'h8A;
    stat_a[239:232] = 8'h25;
    stat_b[15:8]    = 8'hC7;
    stat_b[39:32]   = 8'h3E;
    stat_b[47:40]   = 8'h52;
    test_reset();
    test_pixel_map();
    test_status_live();
    test_gap();
    test_reveal();
    test_reveal_ignore();
    test_reset_mid_reveal();
    test_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
